// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - burst reader: sequential RAM reads to a valid/ready stream
// Hides the one-cycle RAM read latency behind a 2-entry skid FIFO with issue credits.
module ram_stream_reader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  issue_q, issue_d;
  logic [LEN_W-1:0]  deliver_q, deliver_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;
  logic              push, pop;
  logic [2:0]        occ;

  assign push = inflight_q;
  assign pop  = (count_q != 2'd0) && m_ready;
  // A word leaving this cycle frees its slot, which keeps full throughput under m_ready=1.
  assign occ  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issue_d    = issue_q;
    deliver_d  = deliver_q;
    inflight_d = 1'b0;
    if (pop) deliver_d = deliver_q - LEN_W'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = FIN;
          end else begin
            addr_d    = base_addr;
            issue_d   = length;
            deliver_d = length;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (occ < 3'd2) begin
          inflight_d = 1'b1;
          addr_d     = addr_q + ADDR_W'(1);
          issue_d    = issue_q - LEN_W'(1);
          if (issue_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (deliver_d == '0) state_d = FIN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      issue_q    <= '0;
      deliver_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      deliver_q  <= deliver_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= ram_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign ram_addr = addr_q;
  assign ram_we   = 1'b0;
  assign ram_data = '0;
  assign m_valid  = (count_q != 2'd0);
  assign m_data   = fifo_q[rd_ptr_q];
  assign m_last   = m_valid && (deliver_q == LEN_W'(1));

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - scoreboard bench for ram_stream_reader
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] length = '0;
  logic        busy, done, ram_we, m_valid, m_last;
  logic [15:0] ram_addr, ram_data, m_data;
  logic [15:0] ram_q = '0;
  logic        m_ready = 1'b1;

  typedef struct packed {logic [15:0] d; logic l;} exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_hs_cyc = -10;
  int mode = 0;

  ram_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we), .ram_data(ram_data),
    .ram_q(ram_q), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // RAM preloaded with mem[i] = i + 0x100, registered-address read
  always @(posedge clk) ram_q <= ram_addr + 16'h0100;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    bit pat [6] = '{1, 0, 0, 1, 0, 1};
    int idx = 0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: m_ready = 1'b1;
        1: begin m_ready = pat[idx]; idx = (idx + 1) % 6; end
        default: m_ready = 1'b0;
      endcase
    end
  end

  initial begin
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      check("ram_we", ram_we, 0);
      check("ram_data", ram_data, 0);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, prev_data);
        end
        if (done) done_cnt++;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_word", m_data, 32'hDEAD_0000);
          end else begin
            e = exp_q.pop_front();
            check("m_data", m_data, e.d);
            check("m_last", m_last, e.l);
            if (m_last) last_hs_cyc = cyc;
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end
    end
  end

  task automatic run_burst(input logic [15:0] b, input logic [15:0] l, input bit poke);
    logic [15:0] a;
    logic [15:0] addr_before;
    bit          got;
    @(negedge clk);
    addr_before = ram_addr;
    base_addr = b;
    length = l;
    start = 1'b1;
    for (int i = 0; i < int'(l); i++) begin
      a = b + 16'(i);
      exp_q.push_back('{d: a + 16'h0100, l: (i == int'(l) - 1)});
    end
    @(posedge clk);
    #1 start = 1'b0;
    if (l == 16'd0) begin
      @(negedge clk);
      check("zl_done", done, 1);
      check("zl_busy", busy, 1);
      check("zl_valid", m_valid, 0);
      check("zl_addr", ram_addr, addr_before);
      @(negedge clk);
      check("zl_done_clr", done, 0);
      check("zl_busy_clr", busy, 0);
      check("zl_valid2", m_valid, 0);
      return;
    end
    if (mode == 0) begin
      @(negedge clk); check("lat_e0", m_valid, 0);
      @(negedge clk); check("lat_e1", m_valid, 0);
      @(negedge clk); check("lat_e2", m_valid, 1);
    end
    if (poke) begin
      base_addr = 16'h0050;
      length = 16'd3;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    check("done_seen", got, 1);
    if (got) begin
      check("done_after_last", cyc, last_hs_cyc + 1);
      check("busy_with_done", busy, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_cleared", busy, 0);
    end
    check("words_left", exp_q.size(), 0);
  endtask

  initial begin
    int dc;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    check("rst_addr", ram_addr, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_out", {busy, done, m_valid, m_last, m_data, ram_addr}, 0);
    end

    mode = 0; run_burst(16'h0010, 16'd4, 1'b0);
    mode = 1; run_burst(16'h0010, 16'd4, 1'b0);
    mode = 0; run_burst(16'hFFFE, 16'd4, 1'b0);
    run_burst(16'h0000, 16'd0, 1'b0);
    mode = 1; run_burst(16'h0040, 16'd7, 1'b0);

    mode = 2;
    @(negedge clk);
    @(negedge clk);
    base_addr = 16'h0030;
    length = 16'd8;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    check("full_valid", m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", m_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_addr", ram_addr, 0);
    check("abort_data", m_data, 0);
    dc = done_cnt;
    @(negedge clk);
    #2 rst_n = 1'b1;
    mode = 0;
    run_burst(16'h0020, 16'd2, 1'b1);
    check("single_done", done_cnt, dc + 1);
    repeat (10) @(negedge clk);
    check("no_late_words", exp_q.size(), 0);
    check("idle_after", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side client for the on-chip single-port 16-bit feature/weight RAM.
- Accepts a (base, length) burst command and issues sequential RAM addresses.
- Absorbs the RAM's one-cycle registered-address read latency.
- Delivers words on a valid/ready stream toward the CNN datapath (conv/PE array), with full backpressure support and no lost or duplicated words.

Parameters:
- ADDR_W, 16, RAM address width; burst addresses wrap modulo 2^ADDR_W.
- DATA_W, 16, RAM/stream data width.
- LEN_W, 16, width of burst length field.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  input  ADDR_W  first word address, sampled with start.
- length  input  LEN_W  number of words to read, sampled with start.
- busy  output  1  high from accepted start until done pulse (inclusive).
- done  output  1  one-cycle pulse after final word handshake, or after a zero-length command.
- ram_addr  output  ADDR_W  registered address to RAM.
- ram_we  output  1  RAM write enable; held 0 at all times.
- ram_data  output  DATA_W  RAM write data; held 0.
- ram_q  input  DATA_W  RAM read data; corresponds to the ram_addr sampled by the RAM on the previous edge.
- m_data  output  DATA_W  stream data.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream accept.
- m_last  output  1  high with the final word of a burst.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, m_valid, m_last = 0; m_data, ram_addr = 0; ram_we, ram_data = 0.
  - Output FIFO empty; counters cleared.
  - Any in-flight read is discarded. Reset mid-burst aborts the burst with no done pulse.
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE, start=1:
  - If length=0: go to FIN (done next cycle, no RAM access, no stream words).
  - Else: latch remaining-to-issue=length and remaining-to-deliver=length; ram_addr<=base_addr; go to ISSUE.
- ISSUE:
  - A read is "issued" in a cycle where an address is presented and the credit check passes: FIFO occupancy + in-flight (0/1) < 2.
  - On issue: ram_addr<=ram_addr+1 (mod 2^ADDR_W); issue count decrements; the in-flight flag is set for the next cycle.
  - If the credit check fails, ram_addr holds its value and the read is re-presented. Re-reading the same address is harmless because there is no write.
  - When the last address is issued, go to DRAIN.
- Capture:
  - The in-flight flag set at edge N means ram_q during cycle N+1 is valid.
  - It is pushed into a 2-entry output FIFO at edge N+1.
- DRAIN: wait until remaining-to-deliver=0, then go to FIN.
- FIN: done=1 for exactly one cycle, busy still 1; then go to IDLE with busy=0.
- Stream:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - Handshake when m_valid & m_ready; pop and decrement remaining-to-deliver.
  - m_last=1 when the head word is the final one (remaining-to-deliver=1).
  - m_data/m_valid must stay stable while m_valid=1 & m_ready=0.
- Latency and throughput:
  - start accepted at edge E0 → ram_addr=base after E0 → RAM samples at E1 → FIFO captures at E2 → first m_valid=1 after E2.
  - With m_ready held 1: one word per cycle, no bubbles.
  - done high in the cycle after the last handshake.
- Simultaneous events:
  - FIFO push and pop in the same cycle is allowed; occupancy is unchanged.
  - start while busy is ignored; no effect on the current burst.
- Wrap-around: base_addr=0xFFFE, length=4 reads 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Words are never dropped or duplicated under any m_ready pattern.

Test Plan:
- Reset then idle, m_ready=1 → all outputs 0 and ram_we=0 throughout.
- RAM preloaded mem[i]=i+0x100; start base=0x0010 len=4, m_ready=1 → m_data 0x0110..0x0113 on 4 consecutive cycles, first valid 2 cycles after start edge, m_last on 0x0113, done 1 cycle later, busy cleared the cycle after done.
- Same burst with m_ready toggling 1,0,0,1,0,1… → identical ordered sequence, data stable while stalled, no extra/missing words.
- start base=0xFFFE len=4 → data from 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order.
- start len=0 → done pulse the cycle after start, m_valid never asserts, ram_addr unchanged.
- rst_n pulled low mid-burst with m_ready=0 and FIFO full, then a new start base=0x0020 len=2 → no done for the aborted burst, m_valid cleared immediately, new burst delivers mem[0x20], mem[0x21] correctly; start asserted while busy is ignored.
